// File: rtl/dense_weight_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dense_weight_arbiter_pkg
// Description : Shared constants for the dense-layer weight RAM arbiter:
//               training dimensions, owner codes, FSM state codes and the
//               round-robin pick helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dense_weight_arbiter_pkg;

    // Training dimensions used to size the RAM word and the legal burst length
    localparam int N_LEN    = 16;
    localparam int HID_DIM  = 64;
    localparam int CHAR_NUM = 16;

    // Owner codes reported on the owner port
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_FWD  = 2'd1;
    localparam logic [1:0] OWN_BQ   = 2'd2;
    localparam logic [1:0] OWN_UPD  = 2'd3;

    // FSM state codes; grant states share their low bits with the owner code
    // so a pick can be turned into a state by zero-extending it.
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GNT_FWD = 3'd1;
    localparam logic [2:0] S_GNT_BQ  = 3'd2;
    localparam logic [2:0] S_GNT_UPD = 3'd3;
    localparam logic [2:0] S_TURN    = 3'd4;

    // Round-robin pick: search starts at the client after the last-served one.
    // req bit 0 = fwd, bit 1 = bq, bit 2 = upd.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
        rr_pick = OWN_NONE;
        case (last)
            OWN_FWD: begin
                if (req[1])      rr_pick = OWN_BQ;
                else if (req[2]) rr_pick = OWN_UPD;
                else if (req[0]) rr_pick = OWN_FWD;
            end
            OWN_BQ: begin
                if (req[2])      rr_pick = OWN_UPD;
                else if (req[0]) rr_pick = OWN_FWD;
                else if (req[1]) rr_pick = OWN_BQ;
            end
            default: begin
                if (req[0])      rr_pick = OWN_FWD;
                else if (req[1]) rr_pick = OWN_BQ;
                else if (req[2]) rr_pick = OWN_UPD;
            end
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dense_weight_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dense_weight_arbiter
// Description : Burst-granularity round-robin arbiter sharing one single-port
//               dense weight RAM between the forward, backward-q and update
//               clients. Grants are registered and double as client run.
// Revision    : 1.0 - initial release
// ============================================================================
module dense_weight_arbiter
    import dense_weight_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int DENSE_DATA_N = 8,
    parameter int MAX_BURST    = HID_DIM * CHAR_NUM / DENSE_DATA_N
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fwd_req,
    input  logic                          bq_req,
    input  logic                          upd_req,
    output logic                          fwd_gnt,
    output logic                          bq_gnt,
    output logic                          upd_gnt,
    input  logic [ADDR_WIDTH-1:0]         fwd_raddr,
    input  logic [ADDR_WIDTH-1:0]         bq_raddr,
    input  logic [ADDR_WIDTH-1:0]         upd_addr,
    input  logic                          upd_we,
    input  logic [DENSE_DATA_N*N_LEN-1:0] upd_wdata,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DENSE_DATA_N*N_LEN-1:0] mem_wdata,
    output logic [1:0]                    owner,
    output logic                          burst_err
);

    localparam int              CNT_W     = $clog2(MAX_BURST + 2);
    localparam logic [CNT_W-1:0] c_cnt_sat = CNT_W'(MAX_BURST + 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_nxt;
    logic [1:0]       w_pick;
    logic [2:0]       r_gnt;
    logic             w_grant_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_err;

    assign w_pick      = rr_pick(r_ptr, {upd_req, bq_req, fwd_req});
    assign w_grant_nxt = (w_state_nxt == S_GNT_FWD) || (w_state_nxt == S_GNT_BQ) ||
                         (w_state_nxt == S_GNT_UPD);

    // Next-state: grant on any request in IDLE, hold for the whole burst, one TURN cycle after
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_pick != OWN_NONE) begin
                    w_state_nxt = {1'b0, w_pick};
                    w_ptr_nxt   = w_pick;
                end
            end
            S_GNT_FWD: if (!fwd_req) w_state_nxt = S_TURN;
            S_GNT_BQ:  if (!bq_req)  w_state_nxt = S_TURN;
            S_GNT_UPD: if (!upd_req) w_state_nxt = S_TURN;
            S_TURN:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Burst length: 1 in the first granted cycle, saturating one past the legal maximum
    always_comb begin
        w_cnt_nxt = '0;
        if (w_grant_nxt) begin
            if (r_state == S_IDLE)       w_cnt_nxt = CNT_W'(1);
            else if (r_cnt == c_cnt_sat) w_cnt_nxt = r_cnt;
            else                         w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // State, pointer, registered grants, burst counter and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= OWN_UPD;
            r_gnt   <= 3'b000;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= {w_state_nxt == S_GNT_UPD, w_state_nxt == S_GNT_BQ,
                        w_state_nxt == S_GNT_FWD};
            r_cnt   <= w_cnt_nxt;
            r_err   <= r_err | (w_cnt_nxt == c_cnt_sat);
        end
    end

    assign fwd_gnt   = r_gnt[0];
    assign bq_gnt    = r_gnt[1];
    assign upd_gnt   = r_gnt[2];
    assign burst_err = r_err;
    // TURN has bit 2 set and IDLE is zero, so both report no owner
    assign owner     = r_state[2] ? OWN_NONE : r_state[1:0];

    // RAM port mux driven from the registered grants
    always_comb begin
        mem_en   = 1'b0;
        mem_addr = '0;
        if (r_gnt[0]) begin
            mem_en   = 1'b1;
            mem_addr = fwd_raddr;
        end else if (r_gnt[1]) begin
            mem_en   = 1'b1;
            mem_addr = bq_raddr;
        end else if (r_gnt[2]) begin
            mem_en   = 1'b1;
            mem_addr = upd_addr;
        end
    end

    assign mem_we    = r_gnt[2] & upd_we;
    assign mem_wdata = upd_wdata;

endmodule
`default_nettype wire
